neokeon_round_state: RTL and testbench

NEOKEON_ROUND_STATE -- requirements
Module: neokeon_round_state

---
 rtl/neokeon_round_state.sv | 109 ++++++++++
 tb/tb_neokeon_round_state.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neokeon_round_state.sv
// Neokeon round state register: loads a block, runs ROUNDS internal writes, then holds the result until it is consumed.
// Optional macro NEOKEON_ROUND_STATE_CLEAR_EN clears the state register on the result handshake and on abort.
module neokeon_round_state #(
   parameter int unsigned DATA_W  = 128,
   parameter int unsigned ROUNDS  = 16,
   parameter int unsigned ROUND_W = 5
) (
   input  logic               inClk,
   input  logic               inRstN,
   input  logic               inExtValid,
   output logic               outExtReady,
   input  logic [DATA_W-1:0]  inExtData,
   input  logic [DATA_W-1:0]  inIntData,
   input  logic               inAbort,
   output logic [DATA_W-1:0]  outData,
   output logic [ROUND_W-1:0] outRound,
   output logic               outBusy,
   output logic               outValid,
   input  logic               inOutReady
);

   localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(ROUNDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [ROUND_W-1:0] round_q, round_d;
   logic               ext_ready_q, ext_ready_d;
   logic               busy_q, busy_d;
   logic               valid_q, valid_d;

   // Next-state, datapath and status decode; abort overrides every other input
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      round_d = round_q;
      if (inAbort) begin
         state_d = IDLE;
         round_d = '0;
`ifdef NEOKEON_ROUND_STATE_CLEAR_EN
         data_d  = '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (inExtValid) begin
                  data_d  = inExtData;
                  round_d = '0;
                  state_d = RUN;
               end
            end
            RUN: begin
               data_d  = inIntData;
               round_d = round_q + ROUND_W'(1);
               if (round_q == LAST_RND) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               // A load request here is deliberately not honoured until IDLE
               if (inOutReady) begin
                  state_d = IDLE;
                  round_d = '0;
`ifdef NEOKEON_ROUND_STATE_CLEAR_EN
                  data_d  = '0;
`endif
               end
            end
            default: begin
               state_d = IDLE;
               round_d = '0;
            end
         endcase
      end
      ext_ready_d = (state_d == IDLE);
      busy_d      = (state_d == RUN);
      valid_d     = (state_d == DONE);
   end

   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
         state_q     <= IDLE;
         data_q      <= '0;
         round_q     <= '0;
         ext_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         round_q     <= round_d;
         ext_ready_q <= ext_ready_d;
         busy_q      <= busy_d;
         valid_q     <= valid_d;
      end
   end

   assign outData     = data_q;
   assign outRound    = round_q;
   assign outExtReady = ext_ready_q;
   assign outBusy     = busy_q;
   assign outValid    = valid_q;

endmodule

// File: tb/tb_neokeon_round_state.sv
// Bench for neokeon_round_state: a ROUNDS=16 and a ROUNDS=1 instance share stimulus and are checked against a cycle model.
module tb_neokeon_round_state;

   localparam int unsigned DW = 128;
   localparam int unsigned RW = 5;
   localparam logic [DW-1:0] K1 = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [DW-1:0] K2 = 128'h00000000000000000000000000001000;
   localparam logic [DW-1:0] K3 = 128'hFFFFFFFFFFFFFFFF0000000000000000;
   localparam logic [DW-1:0] K4 = 128'h0000000000000000FFFFFFFFFFFFFFF0;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          ext_valid = 1'b0;
   logic          abort = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] ext_data = '0;
   logic [DW-1:0] int_data [2];

   logic [DW-1:0] o_data  [2];
   logic [RW-1:0] o_round [2];
   logic          o_ready [2];
   logic          o_busy  [2];
   logic          o_valid [2];

   int n_cmp = 0;
   int n_err = 0;
   bit run_cmp = 1'b0;

   // Behavioural model: mode 0 idle, 1 running, 2 result held
   int            m_mode [2];
   int            m_rnd  [2];
   logic [DW-1:0] m_data [2];
   int            m_rounds [2];

   initial begin
      m_rounds[0] = 16;
      m_rounds[1] = 1;
   end

   always #5 clk = ~clk;

   neokeon_round_state #(.DATA_W(DW), .ROUNDS(16), .ROUND_W(RW)) u_dut16 (
      .inClk(clk), .inRstN(rst_n), .inExtValid(ext_valid), .outExtReady(o_ready[0]),
      .inExtData(ext_data), .inIntData(int_data[0]), .inAbort(abort),
      .outData(o_data[0]), .outRound(o_round[0]), .outBusy(o_busy[0]),
      .outValid(o_valid[0]), .inOutReady(out_ready));

   neokeon_round_state #(.DATA_W(DW), .ROUNDS(1), .ROUND_W(RW)) u_dut1 (
      .inClk(clk), .inRstN(rst_n), .inExtValid(ext_valid), .outExtReady(o_ready[1]),
      .inExtData(ext_data), .inIntData(int_data[1]), .inAbort(abort),
      .outData(o_data[1]), .outRound(o_round[1]), .outBusy(o_busy[1]),
      .outValid(o_valid[1]), .inOutReady(out_ready));

   // Round datapath stand-in: next state is the expected current state plus one
   assign int_data[0] = m_data[0] + DW'(1);
   assign int_data[1] = m_data[1] + DW'(1);

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_mode[i] <= 0;
            m_rnd[i]  <= 0;
            m_data[i] <= '0;
         end else if (abort) begin
            m_mode[i] <= 0;
            m_rnd[i]  <= 0;
`ifdef NEOKEON_ROUND_STATE_CLEAR_EN
            m_data[i] <= '0;
`endif
         end else if (m_mode[i] == 0) begin
            if (ext_valid) begin
               m_mode[i] <= 1;
               m_rnd[i]  <= 0;
               m_data[i] <= ext_data;
            end
         end else if (m_mode[i] == 1) begin
            m_data[i] <= m_data[i] + DW'(1);
            m_rnd[i]  <= m_rnd[i] + 1;
            if (m_rnd[i] + 1 == m_rounds[i]) m_mode[i] <= 2;
         end else if (out_ready) begin
            m_mode[i] <= 0;
            m_rnd[i]  <= 0;
`ifdef NEOKEON_ROUND_STATE_CLEAR_EN
            m_data[i] <= '0;
`endif
         end
      end
   end

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run_cmp) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("model_data%0d", i), o_data[i], m_data[i]);
            chk($sformatf("model_round%0d", i), DW'(o_round[i]), DW'(m_rnd[i]));
            chk($sformatf("model_ready%0d", i), DW'(o_ready[i]), DW'(m_mode[i] == 0));
            chk($sformatf("model_busy%0d", i), DW'(o_busy[i]), DW'(m_mode[i] == 1));
            chk($sformatf("model_valid%0d", i), DW'(o_valid[i]), DW'(m_mode[i] == 2));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_data"}, o_data[0], '0);
      chk({tag, "_round"}, DW'(o_round[0]), '0);
      chk({tag, "_ready"}, DW'(o_ready[0]), DW'(1));
      chk({tag, "_busy"}, DW'(o_busy[0]), '0);
      chk({tag, "_valid"}, DW'(o_valid[0]), '0);
   endtask

   logic [DW-1:0] held;
   logic [DW-1:0] exp_ret;
   int            edges;
   bit            found;

   initial begin
      rst_n = 1'b0;
      #3;
      chk_reset_vals("reset");
      step();
      rst_n   = 1'b1;
      run_cmp = 1'b1;

      // Full 16-round run; ROUNDS=1 instance finishes after one write
      ext_valid = 1'b1;
      ext_data  = K1;
      step();
      ext_valid = 1'b0;
      chk("load_data", o_data[0], K1);
      chk("load_busy", DW'(o_busy[0]), DW'(1));
      edges = 0;
      found = 1'b0;
      for (int e = 1; e <= 40 && !found; e++) begin
         step();
         edges = e;
         if (e == 1) begin
            chk("r1_valid_edge1", DW'(o_valid[1]), DW'(1));
            chk("r1_data_edge1", o_data[1], 128'h0123456789ABCDEF0123456789ABCDF0);
            chk("r1_round_edge1", DW'(o_round[1]), DW'(1));
         end
         if (o_valid[0]) found = 1'b1;
      end
      chk("valid_edge", DW'(edges), DW'(16));
      chk("done_data", o_data[0], 128'h0123456789ABCDEF0123456789ABCDFF);
      chk("done_round", DW'(o_round[0]), DW'(16));

      // Result holds while the consumer stalls
      held = o_data[0];
      for (int c = 0; c < 10; c++) step();
      chk("hold_data", o_data[0], held);
      chk("hold_valid", DW'(o_valid[0]), DW'(1));

      // Handshake with a coincident load request: no load on that edge
      out_ready = 1'b1;
      ext_valid = 1'b1;
      ext_data  = K2;
      step();
      out_ready = 1'b0;
`ifdef NEOKEON_ROUND_STATE_CLEAR_EN
      exp_ret = '0;
`else
      exp_ret = 128'h0123456789ABCDEF0123456789ABCDFF;
`endif
      chk("hs_ready", DW'(o_ready[0]), DW'(1));
      chk("hs_round", DW'(o_round[0]), '0);
      chk("hs_no_load", o_data[0], exp_ret);
      step();
      ext_valid = 1'b0;
      chk("hs_next_load_busy", DW'(o_busy[0]), DW'(1));
      chk("hs_next_load_data", o_data[0], K2);

      // Abort at round 5
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         if (o_round[0] == RW'(5)) found = 1'b1;
         else step();
      end
      chk("abort_round5_reached", DW'(found), DW'(1));
      abort = 1'b1;
      step();
      abort = 1'b0;
`ifdef NEOKEON_ROUND_STATE_CLEAR_EN
      exp_ret = '0;
`else
      exp_ret = 128'h00000000000000000000000000001005;
`endif
      chk("abort_ready", DW'(o_ready[0]), DW'(1));
      chk("abort_round", DW'(o_round[0]), '0);
      chk("abort_data", o_data[0], exp_ret);

      // Asynchronous reset mid-run, then load on the first edge after release
      ext_valid = 1'b1;
      ext_data  = K3;
      step();
      ext_valid = 1'b0;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrun_reset");
      ext_valid = 1'b1;
      ext_data  = K4;
      step();
      rst_n = 1'b1;
      step();
      ext_valid = 1'b0;
      chk("post_reset_busy", DW'(o_busy[0]), DW'(1));
      chk("post_reset_data", o_data[0], K4);

      // Back-to-back blocks with the consumer always ready
      out_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         ext_data  = {$urandom, $urandom, $urandom, $urandom};
         ext_valid = 1'b1;
         found = 1'b0;
         for (int c = 0; c < 60 && !found; c++) begin
            step();
            ext_valid = 1'b0;
            if (o_valid[0]) found = 1'b1;
         end
         chk($sformatf("b2b_done%0d", b), DW'(found), DW'(1));
         step();
      end
      out_ready = 1'b0;
      step();
      step();

      run_cmp = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
